// File: rtl/mux.sv
// rtl/mux.sv - two-input mux with registered copy, sampled select and saturating select-transition counter
module mux #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sel_changes
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             sel_prev_q;
    logic             sel_prev_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sel_edge;
    logic             cnt_sat;

    // Combinational select; an unknown select drives X rather than quietly picking a.
    always_comb begin
        case (sel)
            1'b0:    o = a;
            1'b1:    o = b;
            default: o = {WIDTH{1'bx}};
        endcase
    end

    // Transition detect against the previously sampled select, and counter saturation flag.
    always_comb begin
        sel_edge = sel ^ sel_prev_q;
        cnt_sat  = (cnt_q == {CNT_W{1'b1}});
    end

    // Next-state: capture the live mux result and select, bump the counter unless it is pinned.
    always_comb begin
        out_d      = o;
        sel_prev_d = sel;
        cnt_d      = cnt_q;
        if (sel_edge && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset wins over any same-cycle update, including a count.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            sel_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            out_q      <= out_d;
            sel_prev_q <= sel_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_q         = out_q;
    assign sel_q       = sel_prev_q;
    assign sel_changes = cnt_q;

endmodule

// File: tb/tb_mux.sv
// tb/tb_mux.sv - randomized and directed self-checking bench for mux against a behavioural model
module tb_mux;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        a1, b1;
    logic [7:0]  a8, b8;
    logic        o1, oq1, selq1;
    logic [15:0] cnt1;
    logic [7:0]  o8, oq8;
    logic        selq8;
    logic [2:0]  cnt8;

    int chk_count;
    int err_count;

    // Behavioural model state
    logic        m_selq;
    logic        m_oq1;
    logic [7:0]  m_oq8;
    int          m_cnt16;
    int          m_cnt3;
    logic [7:0]  held_oq8;

    mux #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel),
        .o(o1), .o_q(oq1), .sel_q(selq1), .sel_changes(cnt1)
    );

    mux #(.WIDTH(8), .CNT_W(3)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel),
        .o(o8), .o_q(oq8), .sel_q(selq8), .sel_changes(cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_count++;
        assert (obs === exp) else begin
            err_count++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check the combinational path, clock, advance the model, check registers.
    task automatic step(input logic r, input logic s, input logic ia1, input logic ib1,
                        input logic [7:0] ia8, input logic [7:0] ib8);
        rst = r; sel = s; a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8;
        #1;
        check("o_w1", 16'(o1), 16'(s ? ib1 : ia1));
        check("o_w8", 16'(o8), 16'(s ? ib8 : ia8));
        @(posedge clk);
        if (r) begin
            m_oq1 = 1'b0; m_oq8 = 8'h00; m_selq = 1'b0; m_cnt16 = 0; m_cnt3 = 0;
        end else begin
            m_oq1 = s ? ib1 : ia1;
            m_oq8 = s ? ib8 : ia8;
            if (s != m_selq) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt3 < 7) m_cnt3++;
            end
            m_selq = s;
        end
        #1;
        check("oq_w1", 16'(oq1), 16'(m_oq1));
        check("oq_w8", 16'(oq8), 16'(m_oq8));
        check("selq_w1", 16'(selq1), 16'(m_selq));
        check("selq_w8", 16'(selq8), 16'(m_selq));
        check("cnt_w1", cnt1, 16'(m_cnt16));
        check("cnt_w8", 16'(cnt8), 16'(m_cnt3));
    endtask

    initial begin
        chk_count = 0;
        err_count = 0;
        m_selq = 1'b0; m_oq1 = 1'b0; m_oq8 = 8'h00; m_cnt16 = 0; m_cnt3 = 0;

        // Zero-latency select with no clock edge in between, while reset is held.
        rst = 1'b1; a1 = 1'b0; b1 = 1'b1; a8 = 8'hA5; b8 = 8'h3C; sel = 1'b0;
        #1;
        check("nclk_o_sel0", 16'(o1), 16'h0000);
        check("nclk_o8_sel0", 16'(o8), 16'h00A5);
        sel = 1'b1;
        #1;
        check("nclk_o_sel1", 16'(o1), 16'h0001);
        check("nclk_o8_sel1", 16'(o8), 16'h003C);

        // Reset for two cycles; registers must come out zero.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C);
        check("rst_cnt", cnt1, 16'h0000);
        check("rst_oq8", 16'(oq8), 16'h0000);

        // First edge after release with sel=1 counts once; then keep toggling for 10 cycles total.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i % 2 == 0), 1'b0, 1'b1, 8'hA5, 8'h3C);
            check("tog_oq8", 16'(oq8), (i % 2 == 0) ? 16'h003C : 16'h00A5);
        end
        check("tog_cnt16", cnt1, 16'd10);
        check("tog_cnt3_sat", 16'(cnt8), 16'd7);

        // Restart, count to 5, then pulse reset mid-toggle.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i % 2 == 0), 1'b0, 1'b1, 8'hA5, 8'h3C);
        end
        check("mid_cnt5", cnt1, 16'd5);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C);
        check("mid_rst_cnt", cnt1, 16'd0);
        check("mid_rst_oq", 16'(oq1), 16'd0);
        check("mid_rst_selq", 16'(selq1), 16'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C);
        check("resume_cnt", cnt1, 16'd1);

        // Hold select steady for 20 cycles.
        held_oq8 = oq8;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C);
        end
        check("hold_cnt", cnt1, 16'd1);
        check("hold_oq8", 16'(oq8), 16'(held_oq8));

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", chk_count, err_count);
        $finish;
    end

endmodule
